// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word requests over req/ack, holds the fetched
// instruction until consumed, and computes PC+4 / LEGv8 branch targets.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic        uncond_br,
  input  logic [25:0] br_addr26,
  input  logic [18:0] cond_addr19,
  input  logic        flush,
  input  logic [63:0] flush_pc
);

  typedef enum logic [1:0] {S_REQ, S_DRAIN, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;

  logic [63:0] flush_tgt;
  logic [63:0] br_off;
  logic [63:0] next_pc;

  assign flush_tgt = flush_pc & ~64'd3;
  assign br_off    = uncond_br ? {{38{br_addr26[25]}}, br_addr26}
                               : {{45{cond_addr19[18]}}, cond_addr19};
  assign next_pc   = br_taken ? ipc_q + (br_off << 2) : ipc_q + 64'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_REQ;
    else          state_q <= state_d;
  end

  // req_q is low only in the first REQ cycle after reset; an ack there is not ours.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (flush)                   state_d = (req_q && !imem_ack) ? S_DRAIN : S_REQ;
        else if (req_q && imem_ack)  state_d = S_HOLD;
      end
      S_DRAIN: if (imem_ack)                state_d = S_REQ;
      S_HOLD:  if (flush || instr_ready)    state_d = S_REQ;
      default:                              state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (flush)                                   pc_d = flush_tgt;
    else if (state_q == S_HOLD && instr_ready)   pc_d = next_pc;
    if (state_q == S_REQ && req_q && imem_ack && !flush) begin
      instr_d = imem_rdata;
      ipc_d   = pc_q;
    end
    valid_d = (state_d == S_HOLD);
    req_d   = (state_d != S_HOLD);
    // The in-flight address stays frozen through DRAIN while pc tracks flushes.
    addr_d  = (state_d == S_REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [63:0] RPC = 64'h100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        uncond_br = 1'b0;
  logic [25:0] br_addr26 = '0;
  logic [18:0] cond_addr19 = '0;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = '0;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_taken(br_taken), .uncond_br(uncond_br),
    .br_addr26(br_addr26), .cond_addr19(cond_addr19),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 0; instr_ready = 0; br_taken = 0; uncond_br = 0;
    br_addr26 = '0; cond_addr19 = '0; flush = 0; flush_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // Park the unit in HOLD with instr_pc = a (a word aligned).
  task automatic load_hold(input logic [63:0] a);
    instr_ready = 0; flush = 1; flush_pc = a; imem_ack = 1;
    step();
    flush = 0;
    step();
    imem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h exp 0", instr); end
    n_cmp++; if (instr_pc !== 64'h0) begin n_err++; $display("FAIL rst_ipc got %h exp 0", instr_pc); end
    @(posedge clk); #1 reset_n = 1;
    step();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_first_req got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== RPC) begin n_err++; $display("FAIL rst_first_addr got %h exp %h", imem_addr, RPC); end
  endtask

  task automatic test_sequential();
    logic [63:0] a;
    do_reset();
    imem_ack = 1; instr_ready = 1;
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      a = RPC + 64'(4 * i);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_err++; $display("FAIL seq_req%0d got %b/%h exp 1/%h", i, imem_req, imem_addr, a); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_novalid%0d got %b exp 0", i, instr_valid); end
      step();
      n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_err++; $display("FAIL seq_valid%0d got v%b r%b exp v1 r0", i, instr_valid, imem_req); end
      n_cmp++; if (instr_pc !== a || instr !== mem_word(a)) begin n_err++; $display("FAIL seq_data%0d got %h/%h exp %h/%h", i, instr_pc, instr, a, mem_word(a)); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    load_hold(64'h200);
    instr_ready = 1; br_taken = 1; uncond_br = 1; br_addr26 = 26'h3FF_FFFE;
    step();
    idle_inputs();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h1F8) begin n_err++; $display("FAIL br_uncond got %b/%h exp 1/1f8", imem_req, imem_addr); end
    load_hold(64'h200);
    instr_ready = 1; br_taken = 1; uncond_br = 0; cond_addr19 = 19'h10; br_addr26 = 26'h155;
    step();
    idle_inputs();
    n_cmp++; if (imem_addr !== 64'h240) begin n_err++; $display("FAIL br_cond got %h exp 240", imem_addr); end
  endtask

  task automatic test_stall();
    load_hold(64'h300);
    for (int unsigned i = 0; i < 5; i++) begin
      instr_ready = 0; br_taken = 1'($urandom); imem_ack = 1'($urandom);
      br_addr26 = 26'($urandom);
      step();
      n_cmp++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 64'h300 || instr !== mem_word(64'h300)) begin
        n_err++;
        $display("FAIL stall%0d got v%b r%b %h/%h exp v1 r0 300/%h", i, instr_valid, imem_req, instr_pc, instr, mem_word(64'h300));
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush_drain();
    logic [31:0] dropped;
    dropped = mem_word(64'h404);
    load_hold(64'h400);
    instr_ready = 1;
    step();
    instr_ready = 0; flush = 1; flush_pc = 64'h1003;
    step();
    flush = 0; flush_pc = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h404) begin n_err++; $display("FAIL drain_hold%0d got %b/%h exp 1/404", i, imem_req, imem_addr); end
      if (i < 2) step();
    end
    imem_ack = 1;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 64'h1000) begin n_err++; $display("FAIL drain_restart got v%b %h exp v0 1000", instr_valid, imem_addr); end
    n_cmp++; if (instr === dropped) begin n_err++; $display("FAIL drain_dropped got %h exp not %h", instr, dropped); end
    step();
    imem_ack = 0;
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 64'h1000 || instr !== mem_word(64'h1000)) begin n_err++; $display("FAIL drain_refetch got v%b %h/%h exp v1 1000/%h", instr_valid, instr_pc, instr, mem_word(64'h1000)); end
  endtask

  task automatic test_flush_priority();
    load_hold(64'h500);
    flush = 1; flush_pc = 64'h2000; instr_ready = 1; br_taken = 1; uncond_br = 1; br_addr26 = 26'h5;
    step();
    idle_inputs();
    n_cmp++; if (imem_addr !== 64'h2000 || instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_prio got %h v%b exp 2000 v0", imem_addr, instr_valid); end
    load_hold(64'hFFFF_FFFF_FFFF_FFFC);
    instr_ready = 1;
    step();
    idle_inputs();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_err++; $display("FAIL pc_wrap got %b/%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid_drain();
    load_hold(64'h600);
    instr_ready = 1;
    step();
    instr_ready = 0; flush = 1; flush_pc = 64'h700;
    step();
    flush = 0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h604) begin n_err++; $display("FAIL mid_pre got %b/%h exp 1/604", imem_req, imem_addr); end
    imem_ack = 1;
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
      n_err++;
      $display("FAIL mid_async got r%b v%b %h/%h exp r0 v0 0/0", imem_req, instr_valid, instr, instr_pc);
    end
    step(); step();
    n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_ack_ignored got r%b v%b exp r0 v0", imem_req, instr_valid); end
    imem_ack = 0;
    reset_n = 1;
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_err++; $display("FAIL mid_refetch got %b/%h exp 1/%h", imem_req, imem_addr, RPC); end
    imem_ack = 1;
    step();
    imem_ack = 0;
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== RPC) begin n_err++; $display("FAIL mid_refetch_data got v%b %h exp v1 %h", instr_valid, instr_pc, RPC); end
  endtask

  // Reference: busy = request outstanding, drop = its data is to be discarded,
  // have = an instruction is being held for the consumer.
  task automatic test_random();
    bit          busy, drop, have;
    logic [63:0] m_pc, m_faddr, m_ipc, fp;
    logic [31:0] m_instr;
    longint      off;
    do_reset();
    busy = 0; drop = 0; have = 0;
    m_pc = RPC; m_faddr = RPC; m_ipc = '0; m_instr = '0;
    for (int unsigned cyc = 0; cyc < 800; cyc++) begin
      imem_ack    = ($urandom_range(0, 99) < 55);
      instr_ready = ($urandom_range(0, 99) < 60);
      flush       = ($urandom_range(0, 99) < 10);
      flush_pc    = {$urandom, $urandom};
      br_taken    = 1'($urandom);
      uncond_br   = 1'($urandom);
      br_addr26   = 26'($urandom);
      cond_addr19 = 19'($urandom);
      fp = flush_pc & ~64'd3;
      if (have) begin
        if (flush) begin
          have = 0; busy = 1; m_pc = fp; m_faddr = m_pc;
        end else if (instr_ready) begin
          off = uncond_br ? longint'($signed(br_addr26)) : longint'($signed(cond_addr19));
          m_pc = br_taken ? m_ipc + 64'(off * 4) : m_ipc + 64'd4;
          have = 0; busy = 1; m_faddr = m_pc;
        end
      end else if (!busy) begin
        if (flush) m_pc = fp;
        busy = 1; m_faddr = m_pc;
      end else begin
        if (flush) m_pc = fp;
        if (imem_ack) begin
          if (drop || flush) begin
            drop = 0; m_faddr = m_pc;
          end else begin
            have = 1; busy = 0; m_ipc = m_faddr; m_instr = mem_word(m_faddr);
          end
        end else if (flush) begin
          drop = 1;
        end
      end
      step();
      n_cmp++; if (imem_req !== busy || instr_valid !== have) begin n_err++; $display("FAIL rnd_ctrl c%0d got r%b v%b exp r%b v%b", cyc, imem_req, instr_valid, busy, have); end
      if (busy) begin
        n_cmp++; if (imem_addr !== m_faddr) begin n_err++; $display("FAIL rnd_addr c%0d got %h exp %h", cyc, imem_addr, m_faddr); end
      end
      n_cmp++; if (instr !== m_instr || instr_pc !== m_ipc) begin n_err++; $display("FAIL rnd_data c%0d got %h/%h exp %h/%h", cyc, instr, instr_pc, m_instr, m_ipc); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_flush_drain();
    test_flush_priority();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
